// File: rtl/decoder.sv
// Registered binary-to-one-hot decoder with enable; turns an index into a select vector
// one cycle later, cleared asynchronously by rst_n.
module decoder #(
  parameter int Input_size = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [Input_size-1:0]      in,
  input  logic                       en,
  output logic [(1<<Input_size)-1:0] out
);

  localparam int OUT_W = 1 << Input_size;

  logic [OUT_W-1:0] out_d;
  logic [OUT_W-1:0] out_q;

  always_comb begin
    out_d = '0;
    if (en) out_d[in] = 1'b1;
  end

  // Output register: no hold mode, every edge loads the freshly decoded value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_q <= '0;
    else        out_q <= out_d;
  end

  assign out = out_q;

endmodule

// File: tb/tb_decoder.sv
// Scoreboard bench for decoder: stimulus pushes expected words, a negedge monitor pops and compares.
module tb_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  in5;
  logic        en5;
  logic [31:0] out5;
  logic        in1, en1;
  logic [1:0]  out1;
  logic [2:0]  in3;
  logic        en3;
  logic [7:0]  out3;

  typedef struct {
    logic [31:0] exp;
    int          due;
  } item_t;

  item_t q[$];
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  decoder #(.Input_size(5)) dut (.clk(clk), .rst_n(rst_n), .in(in5), .en(en5), .out(out5));
  decoder #(.Input_size(1)) u1  (.clk(clk), .rst_n(rst_n), .in(in1), .en(en1), .out(out1));
  decoder #(.Input_size(3)) u3  (.clk(clk), .rst_n(rst_n), .in(in3), .en(en3), .out(out3));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [31:0] exp);
    item_t it;
    it.exp = exp;
    it.due = cyc + 1;
    q.push_back(it);
  endtask

  // Drive one vector just after an edge; its result is due after the following edge.
  task automatic drive(input logic e, input logic [4:0] idx, input logic [31:0] exp);
    @(posedge clk); #1;
    en5 = e;
    in5 = idx;
    push(exp);
  endtask

  // Monitor: compare due scoreboard entries and the at-most-one-hot invariant
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      while (q.size() > 0 && q[0].due <= cyc) begin
        item_t it;
        it = q.pop_front();
        check("scoreboard", out5, it.exp);
      end
    end
    n_cmp++;
    if ($countones(out5) > 1) begin
      n_bad++;
      $display("FAIL popcount: got %h, required at most one bit set", out5);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    en5 = 1'b0; in5 = '0;
    en1 = 1'b0; in1 = 1'b0;
    en3 = 1'b0; in3 = '0;
    #2;
    check("reset_state", out5, 32'h0);
    @(posedge clk); @(posedge clk); #2;
    check("reset_hold", out5, 32'h0);
    rst_n = 1'b1;

    // Basic decode
    drive(1'b1, 5'd5,  32'h0000_0020);
    drive(1'b1, 5'd2,  32'h0000_0004);
    drive(1'b1, 5'd8,  32'h0000_0100);
    drive(1'b1, 5'd31, 32'h8000_0000);
    // Enable gating
    drive(1'b0, 5'd5,  32'h0);
    drive(1'b1, 5'd5,  32'h0000_0020);
    // Boundaries and full sweep
    drive(1'b1, 5'd0,  32'h1);
    drive(1'b1, 5'd31, 32'h8000_0000);
    for (int i = 0; i < 32; i++) drive(1'b1, 5'(i), 32'h1 << i);

    // Asynchronous reset mid-cycle
    drive(1'b1, 5'd8, 32'h0000_0100);
    @(posedge clk); #1;
    check("pre_reset", out5, 32'h0000_0100);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_clear", out5, 32'h0);
    en5 = 1'b1; in5 = 5'd7;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("reset_held", out5, 32'h0);
    end
    rst_n = 1'b1;
    push(32'h0000_0080);

    // Glitch immunity: in toggles mid-cycle, settles at 4
    drive(1'b1, 5'd3, 32'h0000_0008);
    @(posedge clk); #1;
    push(32'h0000_0010);
    in5 = 5'd4;
    #1 in5 = 5'd3;
    #1 in5 = 5'd4;
    #1 in5 = 5'd3;
    check("glitch_stable", out5, 32'h0000_0008);
    #1 in5 = 5'd4;

    // Other parameterisations
    @(posedge clk); #1;
    en1 = 1'b1; in1 = 1'b0;
    en3 = 1'b1; in3 = 3'd6;
    @(posedge clk); #1;
    check("size1_in0", {30'h0, out1}, 32'h1);
    check("size3_in6", {24'h0, out3}, 32'h40);
    in1 = 1'b1;
    en3 = 1'b0;
    @(posedge clk); #1;
    check("size1_in1", {30'h0, out1}, 32'h2);
    check("size3_off", {24'h0, out3}, 32'h0);

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 32'(q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
